time_tag_reader: RTL and testbench
==================================

// Module: time_tag_reader
// PURPOSE
//   Read-side companion to the time-tag capture registers. Each capture strobe pushes
//   the registered DATA_W-bit tag into an on-chip FIFO. Software and DMA logic drain the
//   FIFO through a valid/ready port, so tags are not lost between polls.
//   Overflow events are counted. Sits between the capture register bank and the AXI read mux.
// PARAMETERS
//   DATA_W      32  tag width
//   DEPTH_LOG2  4   log2 of FIFO memory depth (DEPTH = 2**DEPTH_LOG2 words)
//   CNT_W       16  width of the dropped-tag counter
// PORTS
//   clk         in   1             clock
//   reset       in   1             asynchronous, active-high reset
//   cap_strobe  in   1             capture enable; cap_data valid this cycle
//   cap_data    in   DATA_W        captured tag value
//   flush       in   1             sync: discard all buffered tags
//   rd_data     out  DATA_W        head tag
//   rd_valid    out  1             rd_data holds a tag
//   rd_ready    in   1             consumer accepts rd_data
//   level       out  DEPTH_LOG2+1  tags held (memory + output register)
//   ovf_sticky  out  1             set on any dropped tag
//   drop_count  out  CNT_W         dropped tags, saturating
//   ovf_clr     in   1             sync: clear ovf_sticky and drop_count
// BEHAVIOUR
//   - Reset (async): pointers=0, mem_count=0, rd_valid=0, rd_data=0, level=0, ovf_sticky=0,
//     drop_count=0. Memory contents are not reset.
//   - Storage: DEPTH-word memory with a registered read, plus one output register.
//     Total capacity is DEPTH+1.
//   - Pop: rd_valid && rd_ready. rd_data stays stable while rd_valid && !rd_ready.
//     The output register refills from memory when it is empty or being popped and mem_count>0.
//   - Output register FSM:
//     EMPTY -> FETCH when mem_count>0 (memory read issued).
//     FETCH -> FULL (load rd_data, rd_valid=1).
//     FULL -> FETCH on pop with mem_count>0; FULL -> EMPTY on pop with mem_count==0.
//     Back-to-back pops sustain 1 tag/cycle: the read is issued in the pop cycle.
//   - Latency: strobe in cycle n into an empty block gives rd_valid=1 in cycle n+2.
//   - Push accepted iff cap_strobe && (mem_count<DEPTH || memory read issued this cycle).
//     Otherwise the tag is dropped.
//   - Drop: ovf_sticky<=1 and drop_count<=drop_count+1, saturating at 2**CNT_W-1.
//   - Same-cycle drop and ovf_clr: ovf_clr wins, so the result is sticky=0 and count=0.
//   - flush has priority over push and pop in the same cycle.
//     Next cycle: pointers=0, mem_count=0, FSM=EMPTY, rd_valid=0, level=0.
//     flush does not touch ovf_sticky or drop_count.
//   - level = mem_count + (FSM==FETCH || FSM==FULL). It is registered and updates the
//     cycle after the push or pop.
//   - Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. mem_count is DEPTH_LOG2+1 bits.
//   - Mid-operation reset aborts immediately; all buffered tags are lost.
// STRUCTURE
//   - Shared package tt_pkg: TT_DATA_W=32, TT_FIFO_DEPTH_LOG2=4, TT_DROP_CNT_W=16,
//     and the localparam encodings for the output FSM (EMPTY/FETCH/FULL).
//   - Sub-module tt_fifo_mem: simple dual-port RAM
//     (wr_en, wr_addr, wr_data, rd_en, rd_addr, registered rd_data).
//   - Top level holds the pointers, mem_count, output FSM, level and overflow logic.
// TESTING
//   1 Single tag: strobe 0xDEAD_BEEF at cycle 5, rd_ready=1
//     -> rd_valid only in cycle 7, rd_data=0xDEADBEEF, level returns to 0.
//   2 Fill: rd_ready=0, 17 strobes with data 1..17 -> level=17, no drop.
//     18th strobe -> ovf_sticky=1, drop_count=1.
//     Then drain -> data 1..17 in order.
//   3 Full push/pop: level=17, then strobe 0x55 in the same cycle as a pop
//     -> accepted, drop_count unchanged; 0x55 is the last tag read.
//   4 Stream: 64 consecutive strobes with rd_ready=1
//     -> 64 tags out at 1/cycle, in order, no drops, level never above 2.
//   5 Flush: level=5 with rd_valid=1, pulse flush together with a strobe
//     -> next cycle rd_valid=0, level=0, strobe discarded, drop_count unchanged.
//   6 Saturation/clear: CNT_W=4, 20 drops -> drop_count=15.
//     ovf_clr together with a drop -> sticky=0, count=0.
//     Async reset mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared constants and output-stage state encoding for the time-tag read path.
// No logic lives here; it only types the parameters and FSM states used by
// the FIFO memory and the reader top level.
package tt_pkg;

  localparam int TT_DATA_W          = 32;
  localparam int TT_FIFO_DEPTH_LOG2 = 4;
  localparam int TT_DROP_CNT_W      = 16;

  // Output register FSM encodings
  localparam logic [1:0] OUT_EMPTY = 2'd0;
  localparam logic [1:0] OUT_FETCH = 2'd1;
  localparam logic [1:0] OUT_FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = OUT_EMPTY,
    ST_FETCH = OUT_FETCH,
    ST_FULL  = OUT_FULL
  } out_state_t;

  // True when the output stage presents a tag (either straight from the RAM
  // read register or from the held output register).
  function automatic logic holds_tag(input out_state_t s);
    return (s == ST_FETCH) || (s == ST_FULL);
  endfunction

endpackage

// File: rtl/tt_fifo_mem.sv
// Simple dual-port tag RAM with a registered read port.
// Latency: rd_data valid one cycle after rd_en; a same-address write returns old data.
// Backpressure: none; the caller guarantees address and enable legality.
module tt_fifo_mem
  import tt_pkg::*;
#(
  parameter int DATA_W = TT_DATA_W,
  parameter int ADDR_W = TT_FIFO_DEPTH_LOG2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Storage has no reset; read is registered and sees pre-write contents
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/time_tag_reader.sv
// Buffers captured time tags in a RAM FIFO plus an output register for a valid/ready reader.
// Latency: a strobe into an empty block shows rd_valid two cycles later; 1 tag/cycle streaming.
// Backpressure: rd_ready low holds rd_data; when full, further strobes are dropped and counted.
module time_tag_reader
  import tt_pkg::*;
#(
  parameter int DATA_W     = TT_DATA_W,
  parameter int DEPTH_LOG2 = TT_FIFO_DEPTH_LOG2,
  parameter int CNT_W      = TT_DROP_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cap_strobe,
  input  logic [DATA_W-1:0]     cap_data,
  input  logic                  flush,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  ovf_sticky,
  output logic [CNT_W-1:0]      drop_count,
  input  logic                  ovf_clr
);

  localparam int                  DEPTH     = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] MEM_DEPTH = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   mem_count;
  logic [DEPTH_LOG2:0]   mem_count_nxt;
  logic [DEPTH_LOG2:0]   level_nxt;
  out_state_t            state;
  out_state_t            state_nxt;
  logic [DATA_W-1:0]     mem_q;
  logic [DATA_W-1:0]     out_reg;
  logic                  pop;
  logic                  rd_issue;
  logic                  load_out;
  logic                  push_ok;
  logic                  drop;

  tt_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr),
    .wr_data (cap_data),
    .rd_en   (rd_issue),
    .rd_addr (rd_ptr),
    .rd_data (mem_q)
  );

  // In FETCH the freshly read RAM word is presented directly so the tag is
  // visible the cycle it arrives; FULL presents the held copy.
  assign rd_valid = holds_tag(state);
  assign rd_data  = (state == ST_FETCH) ? mem_q : out_reg;
  assign pop      = rd_valid && rd_ready;

  // Output FSM next state, RAM read issue, push acceptance and drop detection
  always_comb begin
    state_nxt     = state;
    rd_issue      = 1'b0;
    load_out      = 1'b0;
    push_ok       = 1'b0;
    drop          = 1'b0;
    mem_count_nxt = mem_count;
    level_nxt     = level;

    if (flush) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (mem_count != '0) begin
            rd_issue  = 1'b1;
            state_nxt = ST_FETCH;
          end
        end
        ST_FETCH: begin
          // Popped in FETCH: refetch immediately to keep 1 tag/cycle
          if (pop) begin
            if (mem_count != '0) begin
              rd_issue = 1'b1;
            end else begin
              state_nxt = ST_EMPTY;
            end
          end else begin
            load_out  = 1'b1;
            state_nxt = ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop) begin
            if (mem_count != '0) begin
              rd_issue  = 1'b1;
              state_nxt = ST_FETCH;
            end else begin
              state_nxt = ST_EMPTY;
            end
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end

    // A full RAM can still take a tag when a word is being read out this cycle
    push_ok = cap_strobe && !flush && ((mem_count < MEM_DEPTH) || rd_issue);
    drop    = cap_strobe && !flush && !push_ok;

    if (flush) begin
      mem_count_nxt = '0;
    end else begin
      mem_count_nxt = mem_count + (DEPTH_LOG2+1)'(push_ok) - (DEPTH_LOG2+1)'(rd_issue);
    end
    level_nxt = mem_count_nxt + (DEPTH_LOG2+1)'(holds_tag(state_nxt));
  end

  // Pointers, occupancy, FSM state and registered level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      level     <= '0;
      state     <= ST_EMPTY;
    end else begin
      state     <= state_nxt;
      mem_count <= mem_count_nxt;
      level     <= level_nxt;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push_ok) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (rd_issue) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end
    end
  end

  // Capture the RAM word when the consumer stalls on a fetched tag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_reg <= '0;
    end else if (load_out) begin
      out_reg <= mem_q;
    end
  end

  // Overflow tracking: clear beats a simultaneous drop; count saturates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
      drop_count <= '0;
    end else if (ovf_clr) begin
      ovf_sticky <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      ovf_sticky <= 1'b1;
      if (drop_count != CNT_MAX) begin
        drop_count <= drop_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_time_tag_reader.sv
// Directed bench for time_tag_reader: default build plus a small
// DEPTH_LOG2=1 / CNT_W=4 build for counter saturation and clear.
module tb_time_tag_reader;

  logic        clk = 1'b0;
  logic        reset;

  logic        cap_strobe, flush, rd_ready, ovf_clr;
  logic [31:0] cap_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic [4:0]  level;
  logic        ovf_sticky;
  logic [15:0] drop_count;

  logic        cap_strobe_b, flush_b, rd_ready_b, ovf_clr_b;
  logic [31:0] cap_data_b;
  logic [31:0] rd_data_b;
  logic        rd_valid_b;
  logic [1:0]  level_b;
  logic        ovf_sticky_b;
  logic [3:0]  drop_count_b;

  int n_vec  = 0;
  int n_miss = 0;
  int got;
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  time_tag_reader dut (
    .clk (clk), .reset (reset),
    .cap_strobe (cap_strobe), .cap_data (cap_data), .flush (flush),
    .rd_data (rd_data), .rd_valid (rd_valid), .rd_ready (rd_ready),
    .level (level), .ovf_sticky (ovf_sticky), .drop_count (drop_count),
    .ovf_clr (ovf_clr)
  );

  time_tag_reader #(.DATA_W (32), .DEPTH_LOG2 (1), .CNT_W (4)) dut_b (
    .clk (clk), .reset (reset),
    .cap_strobe (cap_strobe_b), .cap_data (cap_data_b), .flush (flush_b),
    .rd_data (rd_data_b), .rd_valid (rd_valid_b), .rd_ready (rd_ready_b),
    .level (level_b), .ovf_sticky (ovf_sticky_b), .drop_count (drop_count_b),
    .ovf_clr (ovf_clr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before end of sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    cap_strobe = 0; cap_data = '0; flush = 0; rd_ready = 0; ovf_clr = 0;
    cap_strobe_b = 0; cap_data_b = '0; flush_b = 0; rd_ready_b = 0; ovf_clr_b = 0;
    tick(); tick();

    // Reset state
    chk("rst_valid",  32'(rd_valid),   32'd0);
    chk("rst_data",   rd_data,         32'd0);
    chk("rst_level",  32'(level),      32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    chk("rst_count",  32'(drop_count), 32'd0);
    reset = 1'b0;
    tick(); tick();

    // 1: single tag, consumer ready
    rd_ready = 1; cap_strobe = 1; cap_data = 32'hDEAD_BEEF;
    chk("t1_c0_valid", 32'(rd_valid), 32'd0);
    tick();
    cap_strobe = 0;
    chk("t1_c1_valid", 32'(rd_valid), 32'd0);
    chk("t1_c1_level", 32'(level),    32'd1);
    tick();
    chk("t1_c2_valid", 32'(rd_valid), 32'd1);
    chk("t1_c2_data",  rd_data,       32'hDEAD_BEEF);
    tick();
    chk("t1_c3_valid", 32'(rd_valid), 32'd0);
    chk("t1_c3_level", 32'(level),    32'd0);

    // 2: fill to capacity, overflow by one, drain in order
    rd_ready = 0;
    for (int i = 1; i <= 17; i++) begin
      cap_strobe = 1; cap_data = 32'(i);
      tick();
    end
    cap_strobe = 0;
    chk("t2_level17", 32'(level),      32'd17);
    chk("t2_nodrop",  32'(drop_count), 32'd0);
    chk("t2_nosticky",32'(ovf_sticky), 32'd0);
    cap_strobe = 1; cap_data = 32'd18;
    tick();
    cap_strobe = 0;
    chk("t2_sticky",  32'(ovf_sticky), 32'd1);
    chk("t2_count1",  32'(drop_count), 32'd1);
    chk("t2_level_hold", 32'(level),   32'd17);
    rd_ready = 1;
    for (int i = 1; i <= 17; i++) begin
      chk("t2_drain_valid", 32'(rd_valid), 32'd1);
      chk("t2_drain_data",  rd_data,       32'(i));
      tick();
    end
    chk("t2_empty_valid", 32'(rd_valid), 32'd0);
    chk("t2_empty_level", 32'(level),    32'd0);

    // 3: push into a full block while popping
    rd_ready = 0;
    for (int i = 1; i <= 17; i++) begin
      cap_strobe = 1; cap_data = 32'h100 + 32'(i);
      tick();
    end
    chk("t3_level17", 32'(level), 32'd17);
    rd_ready = 1; cap_strobe = 1; cap_data = 32'h55;
    chk("t3_head", rd_data, 32'h101);
    tick();
    cap_strobe = 0;
    chk("t3_level_after", 32'(level),      32'd17);
    chk("t3_count_same",  32'(drop_count), 32'd1);
    for (int i = 0; i < 17; i++) begin
      exp_v = (i < 16) ? (32'h102 + 32'(i)) : 32'h55;
      chk("t3_drain_valid", 32'(rd_valid), 32'd1);
      chk("t3_drain_data",  rd_data,       exp_v);
      tick();
    end
    chk("t3_empty_valid", 32'(rd_valid), 32'd0);

    // 4: 64-tag stream at full rate
    got = 0;
    for (int j = 0; j < 68; j++) begin
      cap_strobe = (j < 64); cap_data = 32'hA000 + 32'(j);
      chk("t4_valid", 32'(rd_valid), 32'((j >= 2) && (j < 66)));
      if (rd_valid) begin
        chk("t4_data", rd_data, 32'hA000 + 32'(got));
        got++;
      end
      chk("t4_level_le2", 32'(level <= 5'd2), 32'd1);
      tick();
    end
    cap_strobe = 0;
    chk("t4_count_out", 32'(got),        32'd64);
    chk("t4_no_drop",   32'(drop_count), 32'd1);

    // 5: flush with simultaneous strobe
    rd_ready = 0;
    for (int i = 0; i < 5; i++) begin
      cap_strobe = 1; cap_data = 32'hF0 + 32'(i);
      tick();
    end
    cap_strobe = 0;
    chk("t5_level5", 32'(level),    32'd5);
    chk("t5_valid",  32'(rd_valid), 32'd1);
    flush = 1; cap_strobe = 1; cap_data = 32'h77;
    tick();
    flush = 0; cap_strobe = 0;
    chk("t5_f_valid",  32'(rd_valid),   32'd0);
    chk("t5_f_level",  32'(level),      32'd0);
    chk("t5_f_count",  32'(drop_count), 32'd1);
    chk("t5_f_sticky", 32'(ovf_sticky), 32'd1);
    tick(); tick();
    chk("t5_discarded_valid", 32'(rd_valid), 32'd0);
    chk("t5_discarded_level", 32'(level),    32'd0);

    // 6a: saturation on the small build (capacity 3)
    for (int j = 0; j < 17; j++) begin
      cap_strobe_b = 1; cap_data_b = 32'(j);
      tick();
    end
    chk("t6_count14", 32'(drop_count_b), 32'd14);
    for (int j = 0; j < 6; j++) begin
      tick();
    end
    chk("t6_count_sat", 32'(drop_count_b), 32'd15);
    chk("t6_sticky",    32'(ovf_sticky_b), 32'd1);
    chk("t6_level3",    32'(level_b),      32'd3);
    ovf_clr_b = 1;
    tick();
    ovf_clr_b = 0;
    chk("t6_clr_sticky", 32'(ovf_sticky_b), 32'd0);
    chk("t6_clr_count",  32'(drop_count_b), 32'd0);
    tick();
    cap_strobe_b = 0;
    chk("t6_recount", 32'(drop_count_b), 32'd1);

    // 6b: asynchronous reset in the middle of a stream
    rd_ready = 1;
    for (int j = 0; j < 3; j++) begin
      cap_strobe = 1; cap_data = 32'hC0 + 32'(j);
      tick();
    end
    chk("t6_pre_valid", 32'(rd_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_ar_valid",  32'(rd_valid),   32'd0);
    chk("t6_ar_data",   rd_data,         32'd0);
    chk("t6_ar_level",  32'(level),      32'd0);
    chk("t6_ar_sticky", 32'(ovf_sticky), 32'd0);
    chk("t6_ar_count",  32'(drop_count), 32'd0);
    chk("t6_ar_level_b",32'(level_b),    32'd0);
    cap_strobe = 0;
    tick();
    reset = 1'b0;
    tick();
    chk("t6_post_valid", 32'(rd_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
